// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: single-cycle pipeline writebacks versus buffered MUL/DIV
// results, with a starvation guard and a per-register pending-MDU scoreboard.
module wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            pipe_we_i,
    input  logic [4:0]      pipe_rd_addr_i,
    input  logic [XLEN-1:0] pipe_rd_data_i,

    input  logic            mdu_valid_i,
    input  logic [4:0]      mdu_rd_addr_i,
    input  logic [XLEN-1:0] mdu_rd_data_i,
    output logic            mdu_ready_o,

    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_addr_i,

    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic            hazard_o,
    output logic [31:0]     busy_o,

    output logic            pipe_stall_o,

    output logic            rd_we_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;

    entry_t head;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   pipe_valid;
    logic   starved;
    logic   grant_head;
    logic   grant_pipe;

    // Grant decision: pipeline wins unless the buffered head has waited STARVE_LIMIT cycles.
    always_comb begin
        head         = fifo_q[rd_ptr_q];
        fifo_empty   = (count_q == 2'd0);
        mdu_ready_o  = (count_q < 2'd2) & ~rst_i;
        push         = mdu_valid_i & mdu_ready_o;
        pipe_valid   = pipe_we_i & (pipe_rd_addr_i != 5'd0) & ~rst_i;
        starved      = (starve_q == CNT_W'(STARVE_LIMIT));
        grant_head   = ~fifo_empty & (starved | ~pipe_valid);
        grant_pipe   = pipe_valid & ~grant_head;
        pop          = grant_head;
        pipe_stall_o = starved & ~rst_i;
        hazard_o     = (busy_q[rs1_addr_i] | busy_q[rs2_addr_i]) & ~rst_i;
        busy_o       = busy_q;
    end

    // Write port mux; a head with rd=x0 is consumed without a write.
    always_comb begin
        rd_we_o   = 1'b0;
        rd_addr_o = 5'd0;
        rd_data_o = '0;
        if (grant_head) begin
            if (head.addr != 5'd0) begin
                rd_we_o   = 1'b1;
                rd_addr_o = head.addr;
                rd_data_o = head.data;
            end
        end else if (grant_pipe) begin
            rd_we_o   = 1'b1;
            rd_addr_o = pipe_rd_addr_i;
            rd_data_o = pipe_rd_data_i;
        end
    end

    // Next-state: occupancy, starvation age of the head, and scoreboard (set beats clear).
    always_comb begin
        count_d  = count_q;
        starve_d = starve_q;
        busy_d   = busy_q;

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end

        if (fifo_empty || grant_head) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if (grant_head && (head.addr != 5'd0)) begin
            busy_d[head.addr] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_addr_i != 5'd0)) begin
            busy_d[issue_rd_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{addr: mdu_rd_addr_i, data: mdu_rd_data_i};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, 32, data width of register write port.
REQ-002 Parameter STARVE_LIMIT, 4, cycles an MDU result may wait before it forces a grant.
REQ-003 Port clk_i  in  1  clock; all state updates on rising edge.
REQ-004 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 Port pipe_we_i / pipe_rd_addr_i / pipe_rd_data_i  in  1/5/XLEN  single-cycle pipeline writeback request.
REQ-006 Port mdu_valid_i / mdu_rd_addr_i / mdu_rd_data_i  in  1/5/XLEN  MUL/DIV result offer.
REQ-007 Port mdu_ready_o  out  1  MDU result accepted when mdu_valid_i & mdu_ready_o.
REQ-008 Port issue_valid_i / issue_rd_addr_i  in  1/5  MDU instruction issued with destination rd.
REQ-009 Port rs1_addr_i / rs2_addr_i  in  5/5  decode-stage source registers.
REQ-010 Port hazard_o  out  1  a decode source is pending an MDU result.
REQ-011 Port busy_o  out  32  per-register pending-MDU scoreboard.
REQ-012 Port pipe_stall_o  out  1  pipeline must hold its writeback this cycle.
REQ-013 Port rd_we_o / rd_addr_o / rd_data_o  out  1/5/XLEN  single register-file write port.

Function
REQ-014 Two-entry FIFO SHALL buffer MDU results; mdu_ready_o = (count < 2) and not in reset.
REQ-015 No push-to-write bypass: result accepted in cycle N SHALL appear on rd_* no earlier than N+1.
REQ-016 Full FIFO with simultaneous pop SHALL NOT accept a push that cycle (ready depends on count only).
REQ-017 Pipeline request SHALL be valid only when pipe_we_i=1 and pipe_rd_addr_i!=0; otherwise ignored.
REQ-018 Normal arbitration: valid pipeline request wins; else FIFO head granted if FIFO non-empty.
REQ-019 Starvation counter SHALL increment each cycle the FIFO is non-empty and head not granted, saturating at STARVE_LIMIT.
REQ-020 When counter == STARVE_LIMIT: pipe_stall_o=1 (combinational), FIFO head granted regardless of pipe_we_i.
REQ-021 Pipeline SHALL re-present stalled writeback next cycle; arbiter holds no copy.
REQ-022 Counter SHALL clear to 0 on any head grant and whenever FIFO is empty.
REQ-023 Head granted: pop; rd_we_o=1, rd_addr_o/rd_data_o = head, except head addr 0 -> pop with rd_we_o=0.
REQ-024 Pipeline granted: rd_we_o=1, rd_addr_o/rd_data_o = pipeline inputs, same cycle (combinational).
REQ-025 No grant: rd_we_o=0, rd_addr_o=0, rd_data_o=0.
REQ-026 At most one write per cycle; pipe_stall_o=0 whenever counter < STARVE_LIMIT.
REQ-027 issue_valid_i with issue_rd_addr_i!=0 SHALL set busy_o[rd] next edge.
REQ-028 Granted head with addr!=0 SHALL clear busy_o[addr] next edge; same-cycle set and clear of one bit -> set wins.
REQ-029 busy_o[0] SHALL always be 0.
REQ-030 hazard_o = busy_o[rs1_addr_i] | busy_o[rs2_addr_i], combinational.
REQ-031 Pipeline writes to a busy register SHALL be performed and SHALL NOT change busy_o.

Reset
REQ-032 On rst_i=1 (any time, mid-operation included): FIFO emptied, counter 0, busy_o all 0, buffered results discarded.
REQ-033 During reset: mdu_ready_o=0, rd_we_o=0, pipe_stall_o=0, hazard_o=0.
REQ-034 First accept possible on first rising edge after rst_i deasserts.

Verification
REQ-035 Empty FIFO, MDU offers x5=0x1234 cycle N, no pipe -> rd_we_o=1, addr 5, data 0x1234 in N+1; busy_o[5] cleared after.
REQ-036 pipe_we_i=1 every cycle (x7), one MDU result queued -> head waits 4 cycles, then pipe_stall_o=1 and x-MDU write in 5th cycle.
REQ-037 Two MDU results queued, third offered -> mdu_ready_o=0 until a pop; third accepted cycle after pop.
REQ-038 issue x9, decode rs2=9 -> hazard_o=1 until MDU x9 written, 0 the next cycle; issue and writeback of x9 same cycle -> busy stays 1.
REQ-039 pipe_we_i=1 with addr 0, FIFO head addr 0 -> no write, head popped, busy_o unchanged.
REQ-040 Assert rst_i asynchronously with two entries buffered -> mdu_ready_o/rd_we_o drop immediately; no queued write after release.
